// File: rtl/i2c_pkg.sv
// Shared state encoding, bus constants and helpers for the I2C target endpoint.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    WR_BYTE  = 4'd3,
    WR_ACK   = 4'd4,
    RD_BYTE  = 4'd5,
    RD_ACK   = 4'd6,
    IGNORE   = 4'd7
  } i2c_state_t;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

  localparam logic [3:0] BIT_CNT_MAX = 4'd9;

  function automatic logic [3:0] satInc(input logic [3:0] value);
    return (value >= BIT_CNT_MAX) ? BIT_CNT_MAX : value + 4'd1;
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: synchronizer, optional stability filter (I2C_TARGET_GLITCH_FILTER_EN)
// and detection of SCL edges plus START/STOP bus conditions.
module i2c_line_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_sclRise,
  output logic o_sclFall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_sclSync;
  logic [SYNC_STAGES-1:0] r_sdaSync;
  logic                   r_sclPrev;
  logic                   r_sdaPrev;
  logic                   w_scl;
  logic                   w_sda;

  // Idle bus is high, so everything resets to 1 to avoid a false event after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sclSync <= '1;
      r_sdaSync <= '1;
      r_sclPrev <= 1'b1;
      r_sdaPrev <= 1'b1;
    end else begin
      r_sclSync <= {r_sclSync[SYNC_STAGES-2:0], i_scl};
      r_sdaSync <= {r_sdaSync[SYNC_STAGES-2:0], i_sda};
      r_sclPrev <= w_scl;
      r_sdaPrev <= w_sda;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] r_sclHist;
  logic [1:0] r_sdaHist;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sclHist <= '1;
      r_sdaHist <= '1;
    end else begin
      r_sclHist <= {r_sclHist[0], r_sclSync[SYNC_STAGES-1]};
      r_sdaHist <= {r_sdaHist[0], r_sdaSync[SYNC_STAGES-1]};
    end
  end

  // A new level is accepted only when the current and two previous samples agree.
  assign w_scl = (r_sclHist == {2{r_sclSync[SYNC_STAGES-1]}}) ? r_sclSync[SYNC_STAGES-1] : r_sclPrev;
  assign w_sda = (r_sdaHist == {2{r_sdaSync[SYNC_STAGES-1]}}) ? r_sdaSync[SYNC_STAGES-1] : r_sdaPrev;
`else
  assign w_scl = r_sclSync[SYNC_STAGES-1];
  assign w_sda = r_sdaSync[SYNC_STAGES-1];
`endif

  assign o_sda     = w_sda;
  assign o_sclRise = w_scl & ~r_sclPrev;
  assign o_sclFall = ~w_scl & r_sclPrev;
  assign o_start   = w_scl & r_sclPrev & r_sdaPrev & ~w_sda;
  assign o_stop    = w_scl & r_sclPrev & ~r_sdaPrev & w_sda;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a 16-bit read word and capturing a 16-bit write word.
// Optional glitch filter on SCL/SDA is enabled with I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h44,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        PT_CK,
  input  logic        RESET,
  input  logic        SCL_I,
  input  logic        SDA_I,
  output logic        SDA_OE,
  input  logic [15:0] TX_DATA,
  output logic [15:0] RX_DATA,
  output logic        RX_VALID,
  output logic        ADDR_HIT,
  output logic        RD_DONE,
  output logic        BUSY,
  output logic [3:0]  ST
);

  i2c_state_t  r_state;
  logic [3:0]  r_bitCnt;
  logic [7:0]  r_shift;
  logic        r_rw;
  logic [15:0] r_shadow;
  logic [15:0] r_hold;
  logic [15:0] r_rxData;
  logic        r_byteIdx;
  logic [1:0]  r_wrCnt;
  logic        r_sdaOe;
  logic        r_rxValid;
  logic        r_addrHit;
  logic        r_rdDone;
  logic        r_busy;

  logic        w_sda;
  logic        w_sclRise;
  logic        w_sclFall;
  logic        w_start;
  logic        w_stop;
  logic [7:0]  w_curByte;

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_lineCond (
    .i_clk     (PT_CK),
    .i_rst     (RESET),
    .i_scl     (SCL_I),
    .i_sda     (SDA_I),
    .o_sda     (w_sda),
    .o_sclRise (w_sclRise),
    .o_sclFall (w_sclFall),
    .o_start   (w_start),
    .o_stop    (w_stop)
  );

  assign w_curByte = r_byteIdx ? r_shadow[7:0] : r_shadow[15:8];

  // Bits are sampled on SCL rise; SDA_OE only moves on SCL fall so the bus is stable while SCL is high.
  always_ff @(posedge PT_CK or posedge RESET) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_bitCnt  <= '0;
      r_shift   <= '0;
      r_rw      <= 1'b0;
      r_shadow  <= '0;
      r_hold    <= '0;
      r_rxData  <= '0;
      r_byteIdx <= 1'b0;
      r_wrCnt   <= '0;
      r_sdaOe   <= 1'b0;
      r_rxValid <= 1'b0;
      r_addrHit <= 1'b0;
      r_rdDone  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_rxValid <= 1'b0;
      r_addrHit <= 1'b0;
      r_rdDone  <= 1'b0;
      if (w_stop) begin
        r_state  <= IDLE;
        r_sdaOe  <= 1'b0;
        r_busy   <= 1'b0;
        r_bitCnt <= '0;
      end else if (w_start) begin
        r_state  <= ADDR;
        r_sdaOe  <= 1'b0;
        r_busy   <= 1'b0;
        r_bitCnt <= '0;
      end else begin
        case (r_state)
          IDLE: ;
          ADDR: begin
            if (w_sclRise) begin
              r_shift  <= {r_shift[6:0], w_sda};
              r_bitCnt <= satInc(r_bitCnt);
            end else if (w_sclFall && r_bitCnt == 4'd8) begin
              r_bitCnt <= '0;
              if (r_shift[7:1] == TARGET_ADDR) begin
                r_state   <= ADDR_ACK;
                r_rw      <= r_shift[0];
                r_sdaOe   <= ~I2C_ACK;
                r_addrHit <= 1'b1;
                r_busy    <= 1'b1;
              end else begin
                r_state <= IGNORE;
                r_sdaOe <= 1'b0;
              end
            end
          end
          ADDR_ACK: begin
            if (w_sclRise) begin
              r_bitCnt <= satInc(r_bitCnt);
            end else if (w_sclFall && r_bitCnt != 4'd0) begin
              r_bitCnt <= '0;
              if (r_rw == I2C_RW_READ) begin
                r_shadow  <= TX_DATA;
                r_byteIdx <= 1'b0;
                r_sdaOe   <= ~TX_DATA[15];
                r_state   <= RD_BYTE;
              end else begin
                r_sdaOe <= 1'b0;
                r_wrCnt <= '0;
                r_state <= WR_BYTE;
              end
            end
          end
          WR_BYTE: begin
            if (w_sclRise) begin
              r_shift  <= {r_shift[6:0], w_sda};
              r_bitCnt <= satInc(r_bitCnt);
            end else if (w_sclFall && r_bitCnt == 4'd8) begin
              r_bitCnt <= '0;
              r_state  <= WR_ACK;
              if (r_wrCnt == 2'd0) begin
                r_hold[15:8] <= r_shift;
                r_sdaOe      <= ~I2C_ACK;
              end else if (r_wrCnt == 2'd1) begin
                r_hold[7:0] <= r_shift;
                r_sdaOe     <= ~I2C_ACK;
              end else begin
                r_sdaOe <= ~I2C_NACK;
              end
            end
          end
          WR_ACK: begin
            if (w_sclRise) begin
              r_bitCnt <= satInc(r_bitCnt);
            end else if (w_sclFall && r_bitCnt != 4'd0) begin
              r_bitCnt <= '0;
              r_sdaOe  <= 1'b0;
              if (r_wrCnt >= 2'd2) begin
                r_state <= IGNORE;
              end else begin
                if (r_wrCnt == 2'd1) begin
                  r_rxData  <= r_hold;
                  r_rxValid <= 1'b1;
                end
                r_wrCnt <= r_wrCnt + 2'd1;
                r_state <= WR_BYTE;
              end
            end
          end
          RD_BYTE: begin
            if (w_sclRise) begin
              r_bitCnt <= satInc(r_bitCnt);
            end else if (w_sclFall && r_bitCnt == 4'd8) begin
              r_bitCnt <= '0;
              r_sdaOe  <= 1'b0;
              r_state  <= RD_ACK;
            end else if (w_sclFall && r_bitCnt != 4'd0) begin
              r_sdaOe <= ~w_curByte[3'd7 - r_bitCnt[2:0]];
            end
          end
          RD_ACK: begin
            if (w_sclRise) begin
              if (w_sda == I2C_NACK) begin
                r_rdDone <= 1'b1;
                r_state  <= IGNORE;
                r_bitCnt <= '0;
              end else begin
                r_byteIdx <= ~r_byteIdx;
                r_bitCnt  <= satInc(r_bitCnt);
              end
            end else if (w_sclFall && r_bitCnt != 4'd0) begin
              r_bitCnt <= '0;
              r_sdaOe  <= ~w_curByte[7];
              r_state  <= RD_BYTE;
            end
          end
          IGNORE:  r_sdaOe <= 1'b0;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign SDA_OE   = r_sdaOe;
  assign RX_DATA  = r_rxData;
  assign RX_VALID = r_rxValid;
  assign ADDR_HIT = r_addrHit;
  assign RD_DONE  = r_rdDone;
  assign BUSY     = r_busy;
  assign ST       = r_state;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench for i2c_target_regs: a bench-side bus master drives directed
// transfers while a transaction-level model predicts ACKs, read bytes and written words.
module tb_i2c_target_regs;

  localparam int Q = 8;

  logic        PT_CK = 1'b0;
  logic        RESET;
  logic        mScl;
  logic        mSda;
  logic        w_sdaBus;
  logic        SDA_OE;
  logic [15:0] txData;
  logic [15:0] RX_DATA;
  logic        RX_VALID;
  logic        ADDR_HIT;
  logic        RD_DONE;
  logic        BUSY;
  logic [3:0]  ST;

  int checks = 0;
  int errors = 0;

  logic [15:0] modelRx = 16'h0000;
  logic [15:0] rxQueue[$];
  logic [15:0] modelShadow = 16'h0000;
  logic [7:0]  modelHoldHi = 8'h00;
  int          modelWrIdx = 0;
  int          modelRdIdx = 0;
  int          expAddrHit = 0;
  int          expRdDone = 0;
  int          expRxValid = 0;
  int          seenAddrHit = 0;
  int          seenRdDone = 0;
  int          seenRxValid = 0;
  bit          expectQuiet = 1'b0;
  bit          checkEnable = 1'b0;
  logic        prevAddrHit = 1'b0;
  logic        prevRdDone = 1'b0;
  logic        prevRxValid = 1'b0;
  logic        dummyBit;
  logic [7:0]  gotByte;
  logic [7:0]  partialAddr;

  assign w_sdaBus = mSda & ~SDA_OE;

  i2c_target_regs #(.TARGET_ADDR(7'h44), .SYNC_STAGES(2)) dut (
    .PT_CK    (PT_CK),
    .RESET    (RESET),
    .SCL_I    (mScl),
    .SDA_I    (w_sdaBus),
    .SDA_OE   (SDA_OE),
    .TX_DATA  (txData),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .ADDR_HIT (ADDR_HIT),
    .RD_DONE  (RD_DONE),
    .BUSY     (BUSY),
    .ST       (ST)
  );

  always #5 PT_CK = ~PT_CK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the DUT against the transaction model.
  always @(negedge PT_CK) begin
    if (checkEnable) begin
      if (RX_VALID) begin
        seenRxValid++;
        if (rxQueue.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rxValidUnexpected: got pulse with RX_DATA %0h, expected no pulse", RX_DATA);
        end else begin
          modelRx = rxQueue.pop_front();
        end
      end
      checkOutput("rxDataModel", RX_DATA, modelRx);
      if (expectQuiet) checkOutput("sdaOeQuiet", SDA_OE, 0);
      checkOutput("pulseWidth", {ADDR_HIT & prevAddrHit, RD_DONE & prevRdDone, RX_VALID & prevRxValid}, 0);
      if (ADDR_HIT) seenAddrHit++;
      if (RD_DONE) seenRdDone++;
      prevAddrHit = ADDR_HIT;
      prevRdDone  = RD_DONE;
      prevRxValid = RX_VALID;
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge PT_CK);
  endtask

  task automatic busStart();
    mSda = 1'b1; waitCycles(Q);
    mScl = 1'b1; waitCycles(Q);
    mSda = 1'b0; waitCycles(Q);
    mScl = 1'b0; waitCycles(Q);
  endtask

  task automatic busStop();
    mSda = 1'b0; waitCycles(Q);
    mScl = 1'b1; waitCycles(Q);
    mSda = 1'b1; waitCycles(Q);
  endtask

  task automatic clockBit(input logic b, output logic sampled);
    mSda = b;    waitCycles(Q);
    mScl = 1'b1; waitCycles(Q);
    sampled = w_sdaBus;
    waitCycles(Q);
    mScl = 1'b0; waitCycles(Q);
  endtask

  task automatic sendByte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clockBit(b[i], s);
    clockBit(1'b1, ack);
  endtask

  task automatic readByte(input logic masterAck, output logic [7:0] data);
    logic s;
    for (int i = 7; i >= 0; i--) clockBit(1'b1, data[i]);
    clockBit(masterAck, s);
  endtask

  task automatic doAddress(input logic [7:0] b);
    logic ack;
    bit   match;
    match = (b[7:1] == 7'h44);
    modelWrIdx = 0;
    modelRdIdx = 0;
    if (match) expAddrHit++;
    if (match && b[0]) modelShadow = txData;
    sendByte(b, ack);
    checkOutput("addrAck", ack, match ? 0 : 1);
  endtask

  task automatic doWrite(input logic [7:0] b);
    logic ack;
    logic expAck;
    expAck = (modelWrIdx < 2) ? 1'b0 : 1'b1;
    if (modelWrIdx == 0) modelHoldHi = b;
    if (modelWrIdx == 1) begin
      rxQueue.push_back({modelHoldHi, b});
      expRxValid++;
    end
    modelWrIdx++;
    sendByte(b, ack);
    checkOutput("writeAck", ack, expAck);
  endtask

  task automatic doRead(input logic masterAck, output logic [7:0] got);
    logic [7:0] exp;
    exp = (modelRdIdx % 2 == 0) ? modelShadow[15:8] : modelShadow[7:0];
    if (masterAck == 1'b1) expRdDone++;
    readByte(masterAck, got);
    checkOutput("readByte", got, exp);
    modelRdIdx++;
  endtask

  task automatic checkCounts(input string tag);
    checkOutput({tag, "AddrHitCount"}, seenAddrHit, expAddrHit);
    checkOutput({tag, "RdDoneCount"}, seenRdDone, expRdDone);
    checkOutput({tag, "RxValidCount"}, seenRxValid, expRxValid);
  endtask

  task automatic applyStimulus();
    // Reset values
    RESET = 1'b1; mScl = 1'b1; mSda = 1'b1; txData = 16'h0000;
    waitCycles(4);
    checkOutput("resetSdaOe", SDA_OE, 0);
    checkOutput("resetRxData", RX_DATA, 0);
    checkOutput("resetPulses", {RX_VALID, ADDR_HIT, RD_DONE}, 0);
    checkOutput("resetBusy", BUSY, 0);
    checkOutput("resetSt", ST, 0);
    RESET = 1'b0;
    checkEnable = 1'b1;
    waitCycles(4);
    checkOutput("idleSt", ST, 0);

    // Read A55A: ACK then NACK
    $display("[TB] read A55A");
    txData = 16'hA55A;
    busStart();
    doAddress(8'h89);
    checkOutput("readBusy", BUSY, 1);
    checkOutput("readStRdByte", ST, 5);
    doRead(1'b0, gotByte);
    checkOutput("readByte0Lit", gotByte, 8'hA5);
    doRead(1'b1, gotByte);
    checkOutput("readByte1Lit", gotByte, 8'h5A);
    checkOutput("readStIgnore", ST, 7);
    checkOutput("readBusyBeforeStop", BUSY, 1);
    busStop();
    checkOutput("readBusyAfterStop", BUSY, 0);
    checkOutput("readStIdle", ST, 0);
    checkCounts("read");

    // Write 1234, then a NACKed fourth byte
    $display("[TB] write 1234");
    busStart();
    doAddress(8'h88);
    checkOutput("writeStWrByte", ST, 3);
    doWrite(8'h12);
    doWrite(8'h34);
    checkOutput("writeRxLit", RX_DATA, 16'h1234);
    doWrite(8'h56);
    checkOutput("writeStIgnore", ST, 7);
    checkOutput("writeRxKept", RX_DATA, 16'h1234);
    busStop();
    checkCounts("write");

    // Address mismatch
    $display("[TB] address mismatch");
    expectQuiet = 1'b1;
    busStart();
    doAddress(8'h8A);
    checkOutput("mismatchSt", ST, 7);
    sendByte(8'h00, dummyBit);
    checkOutput("mismatchStHeld", ST, 7);
    checkOutput("mismatchBusy", BUSY, 0);
    busStop();
    checkOutput("mismatchStIdle", ST, 0);
    expectQuiet = 1'b0;
    checkCounts("mismatch");

    // Read wrap with TX_DATA changing after the address ACK
    $display("[TB] read wrap");
    txData = 16'hA55A;
    busStart();
    doAddress(8'h89);
    txData = 16'h0F0F;
    doRead(1'b0, gotByte);
    checkOutput("wrapByte0Lit", gotByte, 8'hA5);
    doRead(1'b0, gotByte);
    checkOutput("wrapByte1Lit", gotByte, 8'h5A);
    doRead(1'b0, gotByte);
    checkOutput("wrapByte2Lit", gotByte, 8'hA5);
    doRead(1'b1, gotByte);
    checkOutput("wrapByte3Lit", gotByte, 8'h5A);
    busStop();
    checkCounts("wrap");

    // Repeated START after a single-byte write
    $display("[TB] repeated start");
    busStart();
    doAddress(8'h88);
    doWrite(8'h12);
    txData = 16'hC33C;
    busStart();
    doAddress(8'h89);
    doRead(1'b0, gotByte);
    checkOutput("restartByte0Lit", gotByte, 8'hC3);
    doRead(1'b1, gotByte);
    checkOutput("restartByte1Lit", gotByte, 8'h3C);
    busStop();
    checkOutput("restartRxKept", RX_DATA, 16'h1234);
    checkCounts("restart");

    // Reset while the address ACK is being driven
    $display("[TB] reset mid-ACK");
    busStart();
    partialAddr = 8'h88;
    expAddrHit++;
    for (int i = 7; i >= 0; i--) clockBit(partialAddr[i], dummyBit);
    mSda = 1'b1;
    checkOutput("midAckDriven", SDA_OE, 1);
    @(posedge PT_CK);
    #2;
    RESET = 1'b1;
    modelRx = 16'h0000;
    #1;
    checkOutput("asyncResetSdaOe", SDA_OE, 0);
    checkOutput("asyncResetRxData", RX_DATA, 0);
    checkOutput("asyncResetBusy", BUSY, 0);
    checkOutput("asyncResetSt", ST, 0);
    waitCycles(3);
    RESET = 1'b0;
    waitCycles(4);
    checkOutput("postResetSt", ST, 0);
    busStart();
    doAddress(8'h88);
    doWrite(8'hAB);
    doWrite(8'hCD);
    busStop();
    checkOutput("postResetRxLit", RX_DATA, 16'hABCD);
    checkCounts("postReset");
    checkOutput("rxQueueDrained", rxQueue.size(), 0);
  endtask

  initial begin
    applyStimulus();
    waitCycles(4);
    checkEnable = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
